// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier result accumulator slice.
//   MUL_PW    : product width (8x8 multiplier output)
//   MUL_AW    : accumulator / result width
//   MUL_LEN_W : width of the run-length field
//   state_t   : accumulator FSM states
//   eff_len() : maps the raw len field to the real product count (0 -> 16)
package mul_pkg;

  localparam int MUL_PW    = 16;
  localparam int MUL_AW    = 20;
  localparam int MUL_LEN_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // A zero length field encodes the maximum run of 2**MUL_LEN_W products.
  function automatic logic [MUL_LEN_W:0] eff_len(input logic [MUL_LEN_W-1:0] l);
    eff_len = (l == '0) ? ((MUL_LEN_W+1)'(1) << MUL_LEN_W) : {1'b0, l};
  endfunction

endpackage

// File: rtl/mul_res_fifo.sv
// Small result FIFO for completed accumulation runs.
//   clk, rst_n : clock, async active-low reset (contents cleared)
//   push, din  : write request and data (dropped when full without a pop)
//   pop        : read request (ignored when empty)
//   full/empty : occupancy status
//   head       : oldest entry, registered (no path from din)
module mul_res_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push, w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A pop frees the slot the same cycle, so a full FIFO still takes a push.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mul_result_acc.sv
// Accumulates a run of multiplier products and queues the run sum.
//   clk, rst_n           : clock, async active-low reset
//   start, len           : open a run of len products (0 -> 16)
//   prod_valid, prod     : product stream, never back-pressured
//   acc_valid/acc_ready  : result handshake, acc_data is the FIFO head
//   clear_err            : clears sticky flags (a same-cycle event wins)
//   busy                 : run in progress
//   err_stray / err_drop : product outside a run / result lost to full FIFO
module mul_result_acc
  import mul_pkg::*;
#(
  parameter int PW    = MUL_PW,
  parameter int AW    = MUL_AW,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MUL_LEN_W-1:0] len,
  input  logic                 prod_valid,
  input  logic [PW-1:0]        prod,
  input  logic                 acc_ready,
  input  logic                 clear_err,
  output logic                 acc_valid,
  output logic [AW-1:0]        acc_data,
  output logic                 busy,
  output logic                 err_stray,
  output logic                 err_drop
);

  localparam int LW = MUL_LEN_W + 1;

  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic [LW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, w_eff_len;
  logic [AW-1:0] r_acc, w_acc_nxt, w_sum;
  logic          w_push, w_pop, w_full, w_empty, w_stray;

  assign w_eff_len = eff_len(len);
  assign w_cnt_inc = r_cnt + LW'(1);
  // A product taken together with start is the first of a fresh run, so the
  // old accumulator contents must not leak into it.
  assign w_sum     = ((r_state == ACC) ? r_acc : '0) + AW'(prod);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_push      = 1'b0;
    w_stray     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_len_nxt = w_eff_len;
          if (prod_valid) begin
            if (w_eff_len == LW'(1)) begin
              // Single-product run completes without ever entering ACC.
              w_push    = 1'b1;
              w_acc_nxt = w_sum;
              w_cnt_nxt = LW'(1);
            end else begin
              w_acc_nxt   = w_sum;
              w_cnt_nxt   = LW'(1);
              w_state_nxt = ACC;
            end
          end else begin
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ACC;
          end
        end else if (prod_valid) begin
          w_stray = 1'b1;
        end
      end
      ACC: begin
        // start is deliberately not looked at here.
        if (prod_valid) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  assign w_pop = acc_ready && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stray <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_stray <= w_stray | (err_stray & ~clear_err);
      err_drop  <= (w_push & w_full & ~w_pop) | (err_drop & ~clear_err);
    end
  end

  mul_res_fifo #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_sum),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (acc_data)
  );

  assign acc_valid = !w_empty;
  assign busy      = (r_state == ACC);

endmodule

// File: tb/tb_mul_result_acc.sv
module tb_mul_result_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        prod_valid;
  logic [15:0] prod;
  logic        acc_ready;
  logic        clear_err;
  logic        acc_valid;
  logic [19:0] acc_data;
  logic        busy;
  logic        err_stray;
  logic        err_drop;

  int n_tests = 0;
  int n_fail  = 0;

  mul_result_acc #(.PW(16), .AW(20), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .acc_ready  (acc_ready),
    .clear_err  (clear_err),
    .acc_valid  (acc_valid),
    .acc_data   (acc_data),
    .busy       (busy),
    .err_stray  (err_stray),
    .err_drop   (err_drop)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    start = 0; len = 0; prod_valid = 0; prod = 0; clear_err = 0;
  endtask

  initial begin
    rst_n = 0; acc_ready = 1; idle_in();
    #1;
    chk("rst_valid", acc_valid, 0);
    chk("rst_data",  acc_data,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_flags", {err_stray, err_drop}, 0);
    tick(); tick();
    rst_n = 1;

    // Basic run: len 3, products 100/200/300
    start = 1; len = 3; tick();
    start = 0; chk("basic_busy", busy, 1);
    prod_valid = 1; prod = 100; tick();
    prod = 200; tick();
    chk("basic_no_early", acc_valid, 0);
    prod = 300; tick();
    idle_in();
    chk("basic_valid", acc_valid, 1);
    chk("basic_data",  acc_data,  600);
    chk("basic_busy_lo", busy, 0);
    tick();
    chk("basic_popped", acc_valid, 0);

    // Maximum sum: len 0 means 16 products of 65025
    start = 1; len = 0; tick();
    start = 0; prod_valid = 1; prod = 16'd65025;
    for (int i = 0; i < 15; i++) tick();
    chk("max_busy_15", busy, 1);
    tick();
    idle_in();
    chk("max_valid", acc_valid, 1);
    chk("max_data",  acc_data,  1040400);
    chk("max_flags", {err_stray, err_drop}, 0);
    tick();

    // Same-cycle start + product with len 1
    start = 1; len = 1; prod_valid = 1; prod = 42; tick();
    idle_in();
    chk("s1_valid", acc_valid, 1);
    chk("s1_data",  acc_data,  42);
    chk("s1_idle",  busy,      0);
    tick();
    chk("s1_popped", acc_valid, 0);

    // Back-pressure: three len-1 runs into a 2-deep FIFO
    acc_ready = 0;
    start = 1; len = 1; prod_valid = 1; prod = 5; tick();
    chk("bp_head5", acc_data, 5);
    prod = 6; tick();
    prod = 7; tick();
    idle_in();
    chk("bp_drop", err_drop, 1);
    chk("bp_keep_head", acc_data, 5);
    tick();
    chk("bp_hold", acc_data, 5);
    acc_ready = 1; tick();
    chk("bp_rd6_valid", acc_valid, 1);
    chk("bp_rd6", acc_data, 6);
    tick();
    chk("bp_empty", acc_valid, 0);
    clear_err = 1; tick(); clear_err = 0;
    chk("bp_clear", err_drop, 0);

    // Full FIFO with push and pop on the same edge
    acc_ready = 0;
    start = 1; len = 1; prod_valid = 1; prod = 1; tick();
    prod = 2; tick();
    acc_ready = 1; prod = 3; tick();
    idle_in(); acc_ready = 0;
    chk("pp_head2", acc_data, 2);
    chk("pp_nodrop", err_drop, 0);
    acc_ready = 1; tick();
    chk("pp_head3", acc_data, 3);
    chk("pp_valid3", acc_valid, 1);
    tick();
    chk("pp_empty", acc_valid, 0);

    // Stray product, clear, and clear racing a new stray
    prod_valid = 1; prod = 77; tick();
    idle_in();
    chk("stray_set", err_stray, 1);
    chk("stray_nores", acc_valid, 0);
    clear_err = 1; tick();
    chk("stray_clr", err_stray, 0);
    prod_valid = 1; tick();
    idle_in();
    chk("stray_wins", err_stray, 1);
    clear_err = 1; tick(); clear_err = 0;
    chk("stray_clr2", err_stray, 0);

    // start during ACC is ignored (len 2 run, mid-run start with len 5)
    start = 1; len = 2; tick();
    start = 1; len = 5; prod_valid = 1; prod = 10; tick();
    start = 0; len = 0; prod = 20; tick();
    idle_in();
    chk("ign_valid", acc_valid, 1);
    chk("ign_data",  acc_data,  30);
    chk("ign_idle",  busy,      0);
    tick();

    // Reset mid-run after 2 of 4 products (leave a stray flag set first)
    prod_valid = 1; prod = 1; tick();
    start = 1; len = 4; prod_valid = 0; tick();
    start = 0; prod_valid = 1; prod = 1000; tick();
    prod = 2000; tick();
    chk("mr_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("mr_busy0",  busy,      0);
    chk("mr_valid0", acc_valid, 0);
    chk("mr_data0",  acc_data,  0);
    chk("mr_flags0", {err_stray, err_drop}, 0);
    idle_in();
    tick(); rst_n = 1;
    tick();
    chk("mr_nores", acc_valid, 0);
    chk("mr_idle",  busy,      0);
    start = 1; len = 1; prod_valid = 1; prod = 9; tick();
    idle_in();
    chk("mr_new_valid", acc_valid, 1);
    chk("mr_new_data",  acc_data,  9);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_result_acc.md
MUL_RESULT_ACC -- requirements
Module: mul_result_acc

Interface
REQ-001 SHALL have parameter PW, default 16, meaning product width, matched to the 8x8 pipelined multiplier output.
REQ-002 SHALL have parameter AW, default 20, meaning accumulator and result width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning result FIFO entries.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle pulse that opens an accumulation run.
REQ-007 len  input  4  number of products in the run; sampled with start; 0 means 16.
REQ-008 prod_valid  input  1  product strobe, driven by the multiplier's mul_en_out.
REQ-009 prod  input  PW  product, driven by the multiplier's mul_out.
REQ-010 acc_ready  input  1  downstream ready for the result.
REQ-011 clear_err  input  1  clears the sticky error flags.
REQ-012 acc_valid  output  1  result FIFO non-empty.
REQ-013 acc_data  output  AW  FIFO head: sum of one run's products.
REQ-014 busy  output  1  high while in state ACC.
REQ-015 err_stray  output  1  sticky flag: prod_valid seen in IDLE without start.
REQ-016 err_drop  output  1  sticky flag: a completed result was lost because the FIFO was full.

Function
REQ-017 FSM SHALL have two states. IDLE: start moves to ACC, latches the effective len (1..16), and clears acc and cnt. ACC: returns to IDLE on the edge that accepts the final product.
REQ-018 In ACC, each prod_valid cycle SHALL add zero-extended prod to acc and increment cnt. prod is never back-pressured.
REQ-019 If start and prod_valid are both high in IDLE, that product SHALL count as the run's first product.
REQ-020 If len=1, start and prod_valid are both high in IDLE, the result SHALL be pushed on that edge and the FSM SHALL stay in IDLE.
REQ-021 The final product SHALL push acc+prod into the FIFO on the same edge it is accepted; acc_valid rises the cycle after the final prod_valid.
REQ-022 acc SHALL need no overflow handling: 16 x 65025 = 1,040,400 < 2^20. Arithmetic SHALL be unsigned and AW wide.
REQ-023 start while in ACC SHALL be ignored, with no effect on cnt, acc or len.
REQ-024 prod_valid in IDLE without start SHALL be ignored and SHALL set err_stray.
REQ-025 FIFO pop SHALL occur on acc_valid and acc_ready. acc_data SHALL hold stable while acc_valid=1 and acc_ready=0.
REQ-026 Push and pop in the same cycle when full SHALL both succeed, with occupancy unchanged.
REQ-027 Push when full with no pop SHALL discard the new result, keep the stored entries, and set err_drop.
REQ-028 clear_err SHALL clear both flags. A flag event in the same cycle as clear_err SHALL win, leaving the flag set.
REQ-029 Pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with a count register of width clog2(DEPTH+1).

Reset
REQ-030 rst_n low SHALL immediately force IDLE, with acc=0, cnt=0, len register=0, FIFO empty, acc_valid=0, acc_data=0, busy=0, err_stray=0 and err_drop=0.
REQ-031 Reset during ACC SHALL abandon the partial run; no result is produced. After release, the block waits for a new start.
REQ-032 The first edge after rst_n deasserts SHALL be a normal functional edge.

Structure
REQ-033 Shared package mul_pkg SHALL hold MUL_PW=16, MUL_AW=20, MUL_LEN_W=4 and the state enum (IDLE, ACC).
REQ-034 The result FIFO SHALL be a sub-module mul_res_fifo, parameterised by width and DEPTH, exposing push, pop, full, empty, head.
REQ-035 FSM, counter, accumulator and error flags SHALL reside in mul_result_acc; no combinational path SHALL exist from prod to acc_data.

Verification
REQ-036 Basic run: reset, start len=3, prods 100, 200, 300 on three consecutive cycles, acc_ready=1. Required: acc_valid one cycle after the third prod, acc_data=600, busy low that cycle.
REQ-037 Maximum sum: len=0 (16), sixteen prods of 65025. Required: acc_data=1040400, no wrap, err flags 0.
REQ-038 Back-pressure: acc_ready=0, three len=1 runs with prods 5, 6, 7. Required: FIFO holds 5 then 6, err_drop=1, and after ready asserts, reads return 5 then 6.
REQ-039 Strays and ignored start: prod_valid in IDLE without start sets err_stray, then clear_err clears it; start during ACC leaves the len=2 run's sum unchanged.
REQ-040 Reset mid-run: assert rst_n after 2 of 4 prods. Required: all outputs 0 immediately; a new len=1 run with prod 9 gives acc_data=9.
REQ-041 Same-cycle start+prod_valid, len=1, prod=42. Required: acc_valid next cycle, acc_data=42, FSM stays in IDLE.
